spi_rx: RTL and testbench

SPI_RX -- requirements
Module: spi_rx

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_rx_if.sv | 14 +
 rtl/spi_sync.sv | 22 ++
 rtl/spi_rx.sv | 106 ++++++++++
 tb/tb_spi_rx.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI package: receive/transmit FSM state types, default word width
// and a helper for sizing bit counters.
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_SHIFT,
    TX_END
  } tx_state_t;

  // A one-bit word still needs a one-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/spi_rx_if.sv
// Received-word handshake between the SPI receiver and its consumer.
// A word transfers on every clk rising edge where rx_valid and rx_ready are
// both high; the producer holds rx_data/rx_dc stable while rx_valid && !rx_ready.
interface spi_rx_if #(
  parameter int DATA_W = spi_pkg::SPI_DATA_W
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_dc;
  logic              rx_valid;
  logic              rx_ready;

  modport master (output rx_data, rx_dc, rx_valid, input rx_ready);
  modport slave  (input rx_data, rx_dc, rx_valid, output rx_ready);
endinterface

// File: rtl/spi_sync.sv
// N-stage flop synchronizer for one asynchronous input, with a
// configurable reset level so idle bus levels appear during reset.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ff <= {STAGES{RST_VAL}};
    else      ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_rx.sv
// SPI mode-0 slave receiver: oversamples sclk/mosi/cs_n/dc in the clk domain,
// assembles MSB-first words and offers them on a valid/ready port.
module spi_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      spi_sclk,
  input  logic      spi_mosi,
  input  logic      spi_cs_n,
  input  logic      spi_dc,
  spi_rx_if.master  rx,
  output logic      overflow,
  output logic      busy,
  output rx_state_t state_dbg
);

  localparam int                CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_s, mosi_s, cs_s, dc_s;
  logic sclk_q;
  logic rise;
  logic last_edge;
  logic load, drop;

  rx_state_t         state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              dc_q;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(spi_sclk), .q(sclk_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst(rst), .d(spi_cs_n), .q(cs_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dc   (.clk(clk), .rst(rst), .d(spi_dc),   .q(dc_s));

  assign rise      = sclk_s & ~sclk_q;
  assign last_edge = rise && (cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE:  if (!cs_s) state_nxt = SHIFT;
      SHIFT: begin
        if (cs_s)           state_nxt = IDLE;
        else if (last_edge) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = cs_s ? IDLE : SHIFT;
        load      = !rx.rx_valid || rx.rx_ready;
        drop      = rx.rx_valid && !rx.rx_ready;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The counter sits at zero outside an active SHIFT, which clears it on
  // every entry to SHIFT and on a mid-word cs_n abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q      <= 1'b0;
      cnt         <= '0;
      shreg       <= '0;
      dc_q        <= 1'b0;
      overflow    <= 1'b0;
      rx.rx_data  <= '0;
      rx.rx_dc    <= 1'b0;
      rx.rx_valid <= 1'b0;
    end else begin
      sclk_q   <= sclk_s;
      overflow <= drop;
      if (state != SHIFT || cs_s) begin
        cnt <= '0;
      end else if (rise) begin
        shreg <= {shreg[DATA_W-2:0], mosi_s};
        if (last_edge) begin
          cnt  <= '0;
          dc_q <= dc_s;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (load) begin
        rx.rx_data  <= shreg;
        rx.rx_dc    <= dc_q;
        rx.rx_valid <= 1'b1;
      end else if (rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_spi_rx.sv
// Directed bench for spi_rx: SPI master driver tasks, queue-based scoreboard
// on the valid/ready port, hold/overflow checks and a final report.
module tb_spi_rx;
  import spi_pkg::*;

  localparam int W = 8;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  logic      spi_sclk = 1'b0;
  logic      spi_mosi = 1'b0;
  logic      spi_cs_n = 1'b1;
  logic      spi_dc = 1'b0;
  logic      overflow;
  logic      busy;
  rx_state_t state_dbg;

  spi_rx_if #(.DATA_W(W)) rx_if ();

  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  int ovf_cnt = 0;
  logic [W:0] exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  spi_rx #(.DATA_W(W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_cs_n  (spi_cs_n),
    .spi_dc    (spi_dc),
    .rx        (rx_if.master),
    .overflow  (overflow),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard / monitor, sampled on the falling clk edge
  always @(negedge clk) begin
    if (rst) begin
      if (rx_if.rx_valid && rx_if.rx_ready) begin
        check("word_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("rx_word", 32'({rx_if.rx_dc, rx_if.rx_data}), 32'(exp_q.pop_front()));
        acc_cnt++;
      end else if (rx_if.rx_valid && exp_q.size() > 0) begin
        check("hold_word", 32'({rx_if.rx_dc, rx_if.rx_data}), 32'(exp_q[0]));
      end
      if (overflow) ovf_cnt++;
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [W-1:0] data, input logic dc, input int nbits, input int half);
    for (int i = W - 1; i >= W - nbits; i--) begin
      spi_sclk = 1'b0;
      spi_mosi = data[i];
      if (i == W - 1) spi_dc = dc;
      tick(half);
      spi_sclk = 1'b1;
      tick(half);
    end
  endtask

  task automatic start_frame();
    spi_sclk = 1'b0;
    spi_cs_n = 1'b0;
    tick(4);
  endtask

  task automatic end_frame(input int half);
    spi_sclk = 1'b0;
    tick(half);
    spi_cs_n = 1'b1;
    tick(4);
  endtask

  task automatic drain(input string tag);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 200) begin
      tick(1);
      b++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int acc0;
    int ovf0;
    rx_if.rx_ready = 1'b1;

    // Reset state
    #20;
    check("rst_valid", 32'(rx_if.rx_valid), 32'd0);
    check("rst_data", 32'(rx_if.rx_data), 32'd0);
    check("rst_dc", 32'(rx_if.rx_dc), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(4);

    // Single word at clk/8
    acc0 = acc_cnt;
    start_frame();
    check("frame_busy", 32'(busy), 32'd1);
    exp_q.push_back({1'b1, 8'hA5});
    send_bits(8'hA5, 1'b1, W, 4);
    end_frame(4);
    drain("a5_drain");
    check("a5_count", 32'(acc_cnt - acc0), 32'd1);
    tick(1);
    check("a5_valid_clear", 32'(rx_if.rx_valid), 32'd0);

    // Three back-to-back words at clk/4
    acc0 = acc_cnt;
    start_frame();
    exp_q.push_back({1'b0, 8'h2A});
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h10});
    send_bits(8'h2A, 1'b0, W, 2);
    send_bits(8'h00, 1'b1, W, 2);
    send_bits(8'h10, 1'b1, W, 2);
    end_frame(2);
    drain("b2b_drain");
    check("b2b_count", 32'(acc_cnt - acc0), 32'd3);

    // Consumer stalled: second word dropped with an overflow pulse
    ovf0 = ovf_cnt;
    rx_if.rx_ready = 1'b0;
    start_frame();
    exp_q.push_back({1'b1, 8'h11});
    send_bits(8'h11, 1'b1, W, 2);
    send_bits(8'h22, 1'b1, W, 2);
    end_frame(2);
    tick(10);
    check("stall_valid", 32'(rx_if.rx_valid), 32'd1);
    check("stall_data", 32'(rx_if.rx_data), 32'h11);
    check("stall_ovf", 32'(ovf_cnt - ovf0), 32'd1);
    rx_if.rx_ready = 1'b1;
    tick(1);
    check("stall_release", 32'(rx_if.rx_valid), 32'd0);
    check("stall_queue", 32'(exp_q.size()), 32'd0);

    // cs_n abort after 5 bits, then a clean frame
    acc0 = acc_cnt;
    ovf0 = ovf_cnt;
    start_frame();
    send_bits(8'hFF, 1'b1, 5, 2);
    spi_sclk = 1'b0;
    tick(2);
    spi_cs_n = 1'b1;
    tick(6);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(rx_if.rx_valid), 32'd0);
    start_frame();
    exp_q.push_back({1'b0, 8'h3C});
    send_bits(8'h3C, 1'b0, W, 2);
    end_frame(2);
    drain("abort_drain");
    check("abort_count", 32'(acc_cnt - acc0), 32'd1);
    check("abort_ovf", 32'(ovf_cnt - ovf0), 32'd0);

    // Asynchronous reset mid-frame
    start_frame();
    send_bits(8'hF0, 1'b1, 4, 2);
    rst = 1'b0;
    #2;
    check("mid_rst_valid", 32'(rx_if.rx_valid), 32'd0);
    check("mid_rst_data", 32'(rx_if.rx_data), 32'd0);
    check("mid_rst_dc", 32'(rx_if.rx_dc), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(4);
    acc0 = acc_cnt;
    start_frame();
    exp_q.push_back({1'b1, 8'h81});
    send_bits(8'h81, 1'b1, W, 2);
    end_frame(2);
    drain("post_rst_drain");
    check("post_rst_count", 32'(acc_cnt - acc0), 32'd1);

    // sclk activity with cs_n high is ignored
    acc0 = acc_cnt;
    for (int i = 0; i < 16; i++) begin
      spi_sclk = ~spi_sclk;
      spi_mosi = 1'($urandom_range(0, 1));
      tick(2);
      check("idle_busy", 32'(busy), 32'd0);
    end
    tick(6);
    check("idle_valid", 32'(rx_if.rx_valid), 32'd0);
    check("idle_count", 32'(acc_cnt - acc0), 32'd0);

    // Final report
    check("ovf_total", 32'(ovf_cnt), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
